// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store sequencer: FSM states, access-size
// encodings and the byte-count / lane-crossing checks.
package lsu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq0,
    StWait0,
    StReq1,
    StWait1,
    StResp
  } state_e;

  localparam logic [1:0] SizeB = 2'd0;
  localparam logic [1:0] SizeH = 2'd1;
  localparam logic [1:0] SizeW = 2'd2;
  localparam logic [1:0] SizeD = 2'd3;

  // Widest access in bytes; the 2*NB-bit mask span must hold this many ones.
  localparam int unsigned MaxBytes = 8;

  function automatic int unsigned size_bytes(input logic [1:0] size);
    return 32'd1 << size;
  endfunction

  // Error when the access is wider than the bus, or it spills past the last lane
  // and splitting is disabled.
  function automatic logic access_err(input logic [1:0] size, input logic [3:0] lane,
                                      input int unsigned nb, input logic misalign);
    int unsigned bytes;
    bytes = size_bytes(size);
    return (bytes > nb) || (!misalign && ((32'(lane) + bytes) > nb));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: byte-mask generation, store data shift across two
// beats, and load extract with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned NB = DATA_W / 8,
  localparam int unsigned LB = $clog2(NB)
) (
  input  logic [LB-1:0]     lane,
  input  logic [1:0]        size,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_lo,
  input  logic [DATA_W-1:0] rd_hi,
  output logic [NB-1:0]     mask0,
  output logic [NB-1:0]     mask1,
  output logic [DATA_W-1:0] data0,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] rd_data
);

  logic [2*NB-1:0]     mask_full;
  logic [2*DATA_W-1:0] st_full;
  logic [2*DATA_W-1:0] ld_full;
  logic [DATA_W-1:0]   ld_ext;
  logic                sbit;
  int unsigned         nbytes;

  always_comb begin
    nbytes    = size_bytes(size);
    mask_full = (2*NB)'(((32'd1 << nbytes) - 32'd1) << lane);
    st_full   = {{DATA_W{1'b0}}, wr_data} << {lane, 3'b000};
    ld_full   = {rd_hi, rd_lo} >> {lane, 3'b000};
    ld_ext    = ld_full[DATA_W-1:0];

    unique case (size)
      SizeB:   sbit = ld_ext[7];
      SizeH:   sbit = ld_ext[15];
      SizeW:   sbit = ld_ext[31];
      default: sbit = ld_ext[DATA_W-1];
    endcase

    rd_data = ld_ext;
    for (int unsigned i = 0; i < NB; i++) begin
      if (i >= nbytes) rd_data[8*i +: 8] = {8{is_signed & sbit}};
    end
  end

  assign mask0 = mask_full[NB-1:0];
  assign mask1 = mask_full[2*NB-1:NB];
  assign data0 = st_full[DATA_W-1:0];
  assign data1 = st_full[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/lsu_seq.sv
// Load/store sequencer: accepts one core access, issues one or two dmem beats
// (splitting lane-crossing accesses), and returns an extended load result.
module lsu_seq
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MISALIGN = 1,
  localparam int unsigned NB = DATA_W / 8,
  localparam int unsigned LB = $clog2(NB)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [ADDR_W-1:0]    i_base,
  input  logic [ADDR_W-1:0]    i_offset,
  input  logic [1:0]           i_size,
  input  logic                 i_signed,
  input  logic                 i_is_store,
  input  logic [DATA_W-1:0]    i_wr_data,
  output logic                 o_resp_valid,
  output logic [DATA_W-1:0]    o_rd_data,
  output logic                 o_err,
  output logic                 o_mem_valid,
  input  logic                 i_mem_ready,
  output logic [ADDR_W-LB-1:0] o_mem_addr,
  output logic                 o_mem_we,
  output logic [NB-1:0]        o_mem_mask,
  output logic [DATA_W-1:0]    o_mem_wr_data,
  input  logic                 i_mem_rd_valid,
  input  logic [DATA_W-1:0]    i_mem_rd_data
);

  state_e              state_q, state_d;
  logic [ADDR_W-LB-1:0] word_q, word_d;
  logic [LB-1:0]       lane_q, lane_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic                store_q, store_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rd0_q, rd0_d;
  logic [DATA_W-1:0]   rd1_q, rd1_d;

  logic [ADDR_W-1:0]   addr;
  logic [NB-1:0]       mask0, mask1;
  logic [DATA_W-1:0]   data0, data1, ld_data;
  logic                need_beat1;

  assign addr       = i_base + i_offset;
  assign need_beat1 = |mask1;

  lsu_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .lane     (lane_q),
    .size     (size_q),
    .is_signed(signed_q),
    .wr_data  (wdata_q),
    .rd_lo    (rd0_q),
    .rd_hi    (rd1_q),
    .mask0    (mask0),
    .mask1    (mask1),
    .data0    (data0),
    .data1    (data1),
    .rd_data  (ld_data)
  );

  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    lane_d        = lane_q;
    size_d        = size_q;
    signed_d      = signed_q;
    store_d       = store_q;
    err_d         = err_q;
    wdata_d       = wdata_q;
    rd0_d         = rd0_q;
    rd1_d         = rd1_q;
    o_req_ready   = 1'b0;
    o_resp_valid  = 1'b0;
    o_rd_data     = '0;
    o_err         = 1'b0;
    o_mem_valid   = 1'b0;
    o_mem_addr    = '0;
    o_mem_we      = 1'b0;
    o_mem_mask    = '0;
    o_mem_wr_data = '0;

    unique case (state_q)
      StIdle: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          word_d   = addr[ADDR_W-1:LB];
          lane_d   = addr[LB-1:0];
          size_d   = i_size;
          signed_d = i_signed;
          store_d  = i_is_store;
          wdata_d  = i_wr_data;
          rd0_d    = '0;
          rd1_d    = '0;
          err_d    = access_err(i_size, 4'(addr[LB-1:0]), NB, MISALIGN != 0);
          state_d  = err_d ? StResp : StReq0;
        end
      end
      StReq0: begin
        o_mem_valid   = 1'b1;
        o_mem_addr    = word_q;
        o_mem_we      = store_q;
        o_mem_mask    = mask0;
        o_mem_wr_data = data0;
        if (i_mem_ready) begin
          if (!store_q)        state_d = StWait0;
          else if (need_beat1) state_d = StReq1;
          else                 state_d = StResp;
        end
      end
      StWait0: begin
        if (i_mem_rd_valid) begin
          rd0_d   = i_mem_rd_data;
          state_d = need_beat1 ? StReq1 : StResp;
        end
      end
      StReq1: begin
        o_mem_valid   = 1'b1;
        o_mem_addr    = word_q + (ADDR_W-LB)'(1);
        o_mem_we      = store_q;
        o_mem_mask    = mask1;
        o_mem_wr_data = data1;
        if (i_mem_ready) state_d = store_q ? StResp : StWait1;
      end
      StWait1: begin
        if (i_mem_rd_valid) begin
          rd1_d   = i_mem_rd_data;
          state_d = StResp;
        end
      end
      StResp: begin
        o_resp_valid = 1'b1;
        o_err        = err_q;
        o_rd_data    = (err_q || store_q) ? '0 : ld_data;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      word_q   <= '0;
      lane_q   <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      store_q  <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      rd0_q    <= '0;
      rd1_q    <= '0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      lane_q   <= lane_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      store_q  <= store_d;
      err_q    <= err_d;
      wdata_q  <= wdata_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
    end
  end

endmodule

// File: tb/tb_lsu_seq.sv
// Directed bench for lsu_seq: a split-capable DUT plus a MISALIGN=0 twin sharing
// the same stimulus, with a small word-indexed dmem responder and request log.
module tb_lsu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] base = '0, offset = '0, wr_data = '0;
  logic [1:0]  size = '0;
  logic        sgn = 1'b0, is_store = 1'b0;
  logic        mem_rdy = 1'b1;
  logic        mem_rd_valid = 1'b0;
  logic [31:0] mem_rd_data = '0;

  logic        req_ready, resp_valid, err, mem_valid, mem_we;
  logic [31:0] rd_data, mem_wr_data;
  logic [29:0] mem_addr;
  logic [3:0]  mem_mask;

  logic        na_req_ready, na_resp_valid, na_err, na_mem_valid, na_mem_we;
  logic [31:0] na_rd_data, na_mem_wr_data;
  logic [29:0] na_mem_addr;
  logic [3:0]  na_mem_mask;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_req = 0;
  int na_mem_cnt = 0;
  int rd_delay = 1;
  int pend = 0;
  logic [31:0] pend_data = '0;
  logic [31:0] mem_img [16];
  logic [29:0] log_addr [64];
  logic [3:0]  log_mask [64];
  logic [31:0] log_data [64];
  logic        log_we   [64];

  lsu_seq #(.DATA_W(32), .ADDR_W(32), .MISALIGN(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_base(base), .i_offset(offset), .i_size(size), .i_signed(sgn),
    .i_is_store(is_store), .i_wr_data(wr_data), .o_resp_valid(resp_valid),
    .o_rd_data(rd_data), .o_err(err), .o_mem_valid(mem_valid), .i_mem_ready(mem_rdy),
    .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_mask(mem_mask),
    .o_mem_wr_data(mem_wr_data), .i_mem_rd_valid(mem_rd_valid),
    .i_mem_rd_data(mem_rd_data)
  );

  lsu_seq #(.DATA_W(32), .ADDR_W(32), .MISALIGN(0)) u_dut_na (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(na_req_ready),
    .i_base(base), .i_offset(offset), .i_size(size), .i_signed(sgn),
    .i_is_store(is_store), .i_wr_data(wr_data), .o_resp_valid(na_resp_valid),
    .o_rd_data(na_rd_data), .o_err(na_err), .o_mem_valid(na_mem_valid),
    .i_mem_ready(mem_rdy), .o_mem_addr(na_mem_addr), .o_mem_we(na_mem_we),
    .o_mem_mask(na_mem_mask), .o_mem_wr_data(na_mem_wr_data),
    .i_mem_rd_valid(mem_rd_valid), .i_mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (na_mem_valid) na_mem_cnt <= na_mem_cnt + 1;
  end

  // dmem model: logs every accepted beat; loads return after rd_delay cycles
  always @(posedge clk) begin
    mem_rd_valid <= 1'b0;
    if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1) begin
        mem_rd_valid <= 1'b1;
        mem_rd_data  <= pend_data;
      end
    end
    if (mem_valid && mem_rdy) begin
      log_addr[n_req[5:0]] <= mem_addr;
      log_mask[n_req[5:0]] <= mem_mask;
      log_data[n_req[5:0]] <= mem_wr_data;
      log_we[n_req[5:0]]   <= mem_we;
      n_req <= n_req + 1;
      if (!mem_we) begin
        if (rd_delay <= 1) begin
          mem_rd_valid <= 1'b1;
          mem_rd_data  <= mem_img[mem_addr[3:0]];
        end else begin
          pend      <= rd_delay - 1;
          pend_data <= mem_img[mem_addr[3:0]];
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single cycle; t is the acceptance cycle.
  task automatic issue(input logic [31:0] b, input logic [31:0] o, input logic [1:0] sz,
                       input logic sg, input logic st, input logic [31:0] wd,
                       output int t);
    req_valid = 1'b1;
    base      = b;
    offset    = o;
    size      = sz;
    sgn       = sg;
    is_store  = st;
    wr_data   = wd;
    t         = cyc;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output logic got, output logic [31:0] rd, output logic er,
                           output int t);
    got = 1'b0;
    rd  = '0;
    er  = 1'b0;
    t   = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      if (resp_valid) begin
        got = 1'b1;
        rd  = rd_data;
        er  = err;
        t   = cyc;
      end
      step();
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_tests += 5;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mem_valid: got %b want 0", mem_valid); end
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp: got %b want 0", resp_valid); end
    if (rd_data !== 32'h0) begin n_fail++; $display("FAIL rst_rd_data: got %h want 0", rd_data); end
    if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_lw();
    int t, tr, nr;
    logic got, er;
    logic [31:0] rd;
    mem_img[1] = 32'hDEADBEEF;
    nr = n_req;
    issue(32'h100, 32'h4, 2'd2, 1'b0, 1'b0, 32'h0, t);
    n_tests += 3;
    if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL lw_valid_t1: got %b want 1", mem_valid); end
    if (mem_addr !== 30'h41) begin n_fail++; $display("FAIL lw_addr: got %h want 41", mem_addr); end
    if (mem_mask !== 4'b1111) begin n_fail++; $display("FAIL lw_mask: got %b want 1111", mem_mask); end
    wait_resp(got, rd, er, tr);
    n_tests += 5;
    if (got !== 1'b1) begin n_fail++; $display("FAIL lw_resp: got %b want 1", got); end
    if (tr !== t + 3) begin n_fail++; $display("FAIL lw_latency: got %0d want %0d", tr, t + 3); end
    if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h want deadbeef", rd); end
    if (er !== 1'b0) begin n_fail++; $display("FAIL lw_err: got %b want 0", er); end
    if (n_req - nr !== 1) begin n_fail++; $display("FAIL lw_beats: got %0d want 1", n_req - nr); end
  endtask

  task automatic test_lb_lh();
    int t, tr;
    logic got, er;
    logic [31:0] rd;
    mem_img[0] = 32'h80123456;
    issue(32'h100, 32'h3, 2'd0, 1'b1, 1'b0, 32'h0, t);
    n_tests += 2;
    if (mem_mask !== 4'b1000) begin n_fail++; $display("FAIL lb_mask: got %b want 1000", mem_mask); end
    if (mem_addr !== 30'h40) begin n_fail++; $display("FAIL lb_addr: got %h want 40", mem_addr); end
    wait_resp(got, rd, er, tr);
    n_tests++;
    if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_signed: got %h want ffffff80", rd); end
    issue(32'h100, 32'h3, 2'd0, 1'b0, 1'b0, 32'h0, t);
    wait_resp(got, rd, er, tr);
    n_tests++;
    if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lb_unsigned: got %h want 00000080", rd); end
    mem_img[0] = 32'h80017777;
    issue(32'h100, 32'h2, 2'd1, 1'b1, 1'b0, 32'h0, t);
    wait_resp(got, rd, er, tr);
    n_tests++;
    if (rd !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_signed: got %h want ffff8001", rd); end
  endtask

  task automatic test_misalign_store();
    int t, tr, nr, na0;
    logic got, er;
    logic [31:0] rd;
    nr  = n_req;
    na0 = na_mem_cnt;
    issue(32'h100, 32'h2, 2'd2, 1'b0, 1'b1, 32'h11223344, t);
    n_tests += 2;
    if (na_resp_valid !== 1'b1) begin n_fail++; $display("FAIL na_resp: got %b want 1", na_resp_valid); end
    if (na_err !== 1'b1) begin n_fail++; $display("FAIL na_err: got %b want 1", na_err); end
    wait_resp(got, rd, er, tr);
    n_tests += 12;
    if (na_mem_cnt !== na0) begin n_fail++; $display("FAIL na_no_mem: got %0d want %0d", na_mem_cnt, na0); end
    if (got !== 1'b1) begin n_fail++; $display("FAIL sw_resp: got %b want 1", got); end
    if (er !== 1'b0) begin n_fail++; $display("FAIL sw_err: got %b want 0", er); end
    if (rd !== 32'h0) begin n_fail++; $display("FAIL sw_rd: got %h want 0", rd); end
    if (n_req - nr !== 2) begin n_fail++; $display("FAIL sw_beats: got %0d want 2", n_req - nr); end
    if (log_addr[nr[5:0]] !== 30'h40) begin n_fail++; $display("FAIL sw_b0_addr: got %h want 40", log_addr[nr[5:0]]); end
    if (log_mask[nr[5:0]] !== 4'b1100) begin n_fail++; $display("FAIL sw_b0_mask: got %b want 1100", log_mask[nr[5:0]]); end
    if (log_data[nr[5:0]] !== 32'h33440000) begin n_fail++; $display("FAIL sw_b0_data: got %h want 33440000", log_data[nr[5:0]]); end
    if (log_we[nr[5:0]] !== 1'b1) begin n_fail++; $display("FAIL sw_b0_we: got %b want 1", log_we[nr[5:0]]); end
    if (log_addr[(nr + 1) % 64] !== 30'h41) begin n_fail++; $display("FAIL sw_b1_addr: got %h want 41", log_addr[(nr + 1) % 64]); end
    if (log_mask[(nr + 1) % 64] !== 4'b0011) begin n_fail++; $display("FAIL sw_b1_mask: got %b want 0011", log_mask[(nr + 1) % 64]); end
    if (log_data[(nr + 1) % 64] !== 32'h00001122) begin n_fail++; $display("FAIL sw_b1_data: got %h want 00001122", log_data[(nr + 1) % 64]); end
  endtask

  task automatic test_misalign_load();
    int t, tr, nr;
    logic got, er;
    logic [31:0] rd;
    mem_img[0]  = 32'h44332211;
    mem_img[1]  = 32'h88776655;
    mem_img[15] = 32'hBBAA9999;
    issue(32'h0FF, 32'h4, 2'd2, 1'b0, 1'b0, 32'h0, t);
    wait_resp(got, rd, er, tr);
    n_tests++;
    if (rd !== 32'h77665544) begin n_fail++; $display("FAIL lw_split: got %h want 77665544", rd); end
    nr = n_req;
    issue(32'hFFFFFFF0, 32'hE, 2'd2, 1'b0, 1'b0, 32'h0, t);
    wait_resp(got, rd, er, tr);
    n_tests += 5;
    if (rd !== 32'h2211BBAA) begin n_fail++; $display("FAIL wrap_data: got %h want 2211bbaa", rd); end
    if (log_addr[nr[5:0]] !== 30'h3FFFFFFF) begin n_fail++; $display("FAIL wrap_b0_addr: got %h want 3fffffff", log_addr[nr[5:0]]); end
    if (log_addr[(nr + 1) % 64] !== 30'h0) begin n_fail++; $display("FAIL wrap_b1_addr: got %h want 0", log_addr[(nr + 1) % 64]); end
    if (log_mask[nr[5:0]] !== 4'b1100) begin n_fail++; $display("FAIL wrap_b0_mask: got %b want 1100", log_mask[nr[5:0]]); end
    if (log_mask[(nr + 1) % 64] !== 4'b0011) begin n_fail++; $display("FAIL wrap_b1_mask: got %b want 0011", log_mask[(nr + 1) % 64]); end
  endtask

  task automatic test_size_err();
    int t, tr, nr;
    logic got, er;
    logic [31:0] rd;
    nr = n_req;
    issue(32'h100, 32'h0, 2'd3, 1'b0, 1'b0, 32'h0, t);
    wait_resp(got, rd, er, tr);
    n_tests += 5;
    if (got !== 1'b1) begin n_fail++; $display("FAIL ld_resp: got %b want 1", got); end
    if (er !== 1'b1) begin n_fail++; $display("FAIL ld_err: got %b want 1", er); end
    if (rd !== 32'h0) begin n_fail++; $display("FAIL ld_rd: got %h want 0", rd); end
    if (tr !== t + 1) begin n_fail++; $display("FAIL ld_latency: got %0d want %0d", tr, t + 1); end
    if (n_req !== nr) begin n_fail++; $display("FAIL ld_no_mem: got %0d want %0d", n_req, nr); end
  endtask

  task automatic test_stall();
    int t, tr;
    logic got, er;
    logic [31:0] rd;
    mem_rdy = 1'b0;
    issue(32'h200, 32'h5, 2'd1, 1'b0, 1'b1, 32'h0000ABCD, t);
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({mem_valid, mem_we, mem_addr, mem_mask, mem_wr_data} !==
          {1'b1, 1'b1, 30'h81, 4'b0110, 32'h00ABCD00}) begin
        n_fail++;
        $display("FAIL stall_fields[%0d]: got v=%b we=%b a=%h m=%b d=%h want v=1 we=1 a=81 m=0110 d=00abcd00",
                 i, mem_valid, mem_we, mem_addr, mem_mask, mem_wr_data);
      end
      step();
    end
    mem_rdy = 1'b1;
    wait_resp(got, rd, er, tr);
    n_tests += 2;
    if (got !== 1'b1) begin n_fail++; $display("FAIL stall_resp: got %b want 1", got); end
    if (er !== 1'b0) begin n_fail++; $display("FAIL stall_err: got %b want 0", er); end
  endtask

  task automatic test_reset_inflight();
    int t, seen;
    rd_delay   = 4;
    mem_img[0] = 32'h12345678;
    issue(32'h100, 32'h0, 2'd2, 1'b0, 1'b0, 32'h0, t);
    step();
    rst_n = 1'b0;
    #1;
    n_tests += 2;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wait0_ready: got %b want 1", req_ready); end
    if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wait0_mem: got %b want 0", mem_valid); end
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (resp_valid) seen++;
    end
    n_tests++;
    if (seen !== 0) begin n_fail++; $display("FAIL late_data_resp: got %0d want 0", seen); end
    rd_delay = 1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem_img[i] = '0;
    test_reset();
    test_lw();
    test_lb_lh();
    test_misalign_store();
    test_misalign_load();
    test_size_err();
    test_stall();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
